// File: rtl/lsu_ctrl.sv
// MEM-stage load/store sequencer: issues one data-memory transaction per op,
// stalls the pipeline until it completes and hands lane controls to WB.
`timescale 1ns/1ps
module lsu_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_valid,
  input  logic              mem_load,
  input  logic              mem_store,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic              pipe_advance,
  input  logic              flush,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [31:0]       data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata,
  output logic              stall,
  output logic              adel,
  output logic              ades,
  output logic              ld_valid,
  output logic [3:0]        ld_memtoreg,
  output logic [1:0]        ld_offset,
  output logic              ld_lu,
  output logic [31:0]       ld_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t            r_state, w_state_next;
  logic              r_cancel, w_cancel_next;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic              r_wr, r_lu;
  logic [3:0]        r_wstrb;
  logic [31:0]       r_wdata;
  logic [3:0]        r_ld_mask;
  logic [1:0]        r_ld_off;
  logic              r_ld_lu;
  logic [31:0]       r_ld_rdata;

  logic              w_idle, w_misalign, w_new_op, w_ld_load;
  logic [1:0]        w_size;
  logic [3:0]        w_strb, w_ld_mask;
  logic [31:0]       w_wdata;

  assign w_idle     = (r_state == IDLE);
  assign w_size     = (mem_size == 2'd3) ? 2'd2 : mem_size;
  assign w_misalign = ((w_size == 2'd1) && mem_addr[0]) ||
                      ((w_size == 2'd2) && (mem_addr[1:0] != 2'b00));
  assign w_new_op   = w_idle && mem_valid && (mem_load || mem_store) &&
                      !w_misalign && !flush;

  assign adel = w_idle && mem_valid && mem_load  && w_misalign;
  assign ades = w_idle && mem_valid && mem_store && w_misalign;

  // Store lanes: strobes and replicated data so any lane sees the operand
  always_comb begin
    w_strb  = 4'b1111;
    w_wdata = mem_wdata;
    case (w_size)
      2'd0: begin
        w_strb  = 4'b0001 << mem_addr[1:0];
        w_wdata = {4{mem_wdata[7:0]}};
      end
      2'd1: begin
        w_strb  = 4'b0011 << {mem_addr[1], 1'b0};
        w_wdata = {2{mem_wdata[15:0]}};
      end
      default: ;
    endcase
    if (!mem_store) w_strb = 4'b0000;
  end

  always_comb begin
    w_ld_mask = 4'b1111;
    case (r_size)
      2'd0:    w_ld_mask = 4'b0001;
      2'd1:    w_ld_mask = 4'b0011;
      default: w_ld_mask = 4'b1111;
    endcase
    if (r_wr) w_ld_mask = 4'b0000;
  end

  always_comb begin
    w_state_next  = r_state;
    w_cancel_next = r_cancel;
    w_ld_load     = 1'b0;
    case (r_state)
      IDLE: if (w_new_op) w_state_next = REQ;
      REQ: begin
        if (flush) w_cancel_next = 1'b1;
        if (data_addr_ok) w_state_next = WAIT;
      end
      WAIT: begin
        if (flush) w_cancel_next = 1'b1;
        if (data_data_ok) begin
          if (r_cancel || flush) begin
            w_state_next = IDLE;
          end else begin
            w_state_next = HOLD;
            w_ld_load    = 1'b1;
          end
        end
      end
      HOLD: if (pipe_advance || flush) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if (w_state_next == IDLE) w_cancel_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_cancel   <= 1'b0;
      r_addr     <= '0;
      r_size     <= 2'd0;
      r_wr       <= 1'b0;
      r_lu       <= 1'b0;
      r_wstrb    <= 4'b0000;
      r_wdata    <= 32'd0;
      r_ld_mask  <= 4'b0000;
      r_ld_off   <= 2'd0;
      r_ld_lu    <= 1'b0;
      r_ld_rdata <= 32'd0;
    end else begin
      r_state  <= w_state_next;
      r_cancel <= w_cancel_next;
      if (w_new_op) begin
        r_addr  <= mem_addr;
        r_size  <= w_size;
        r_wr    <= mem_store;
        r_lu    <= mem_unsigned;
        r_wstrb <= w_strb;
        r_wdata <= w_wdata;
      end
      if ((r_state == WAIT) && data_data_ok) r_ld_rdata <= data_rdata;
      if (w_ld_load) begin
        r_ld_mask <= w_ld_mask;
        r_ld_off  <= r_addr[1:0];
        r_ld_lu   <= r_lu;
      end
    end
  end

  assign stall       = w_new_op || (r_state == REQ) || (r_state == WAIT);
  assign data_req    = (r_state == REQ);
  assign data_wr     = r_wr;
  assign data_size   = r_size;
  assign data_addr   = r_addr;
  assign data_wstrb  = r_wstrb;
  assign data_wdata  = r_wdata;
  assign ld_valid    = (r_state == HOLD) && !r_wr;
  assign ld_memtoreg = r_ld_mask;
  assign ld_offset   = r_ld_off;
  assign ld_lu       = r_ld_lu;
  assign ld_rdata    = r_ld_rdata;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: expected WB-side results are queued when an op
// is issued and popped when the sequencer leaves WAIT.
`timescale 1ns/1ps
module tb_lsu_ctrl;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              resetn, mem_valid, mem_load, mem_store, mem_unsigned;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              pipe_advance, flush;
  logic              data_req, data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [3:0]        data_wstrb;
  logic [31:0]       data_wdata;
  logic              data_addr_ok, data_data_ok;
  logic [31:0]       data_rdata;
  logic              stall, adel, ades, ld_valid, ld_lu;
  logic [3:0]        ld_memtoreg;
  logic [1:0]        ld_offset;
  logic [31:0]       ld_rdata;

  lsu_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_load(mem_load), .mem_store(mem_store),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .pipe_advance(pipe_advance), .flush(flush),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .stall(stall), .adel(adel), .ades(ades),
    .ld_valid(ld_valid), .ld_memtoreg(ld_memtoreg), .ld_offset(ld_offset),
    .ld_lu(ld_lu), .ld_rdata(ld_rdata)
  );

  typedef struct {
    logic        valid;
    logic [3:0]  mask;
    logic [1:0]  off;
    logic        lu;
    logic [31:0] rdata;
    logic        hold;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    mem_valid = 0; mem_load = 0; mem_store = 0; mem_size = 0;
    mem_addr = 0; mem_wdata = 0; mem_unsigned = 0;
  endtask

  // One complete aligned op with configurable handshake delays
  task automatic do_op(input string nm, input logic ld, input logic [1:0] sz,
                       input logic [31:0] addr, input logic [31:0] wd, input logic lu,
                       input int aok_dly, input int dok_dly, input logic [31:0] rdata,
                       input logic flush_w, input logic [3:0] exp_strb,
                       input logic [31:0] exp_wd, input logic [1:0] exp_sz);
    exp_t e;
    mem_valid = 1; mem_load = ld; mem_store = !ld; mem_size = sz;
    mem_addr = addr; mem_wdata = wd; mem_unsigned = lu;
    #1;
    chk({nm, "_op_stall"}, 32'(stall), 1);
    chk({nm, "_op_req"}, 32'(data_req), 0);
    chk({nm, "_op_aerr"}, 32'(adel | ades), 0);
    step();
    clear_mem();
    for (int i = 0; i <= aok_dly; i++) begin
      data_addr_ok = (i == aok_dly);
      #1;
      chk({nm, "_req"}, 32'(data_req), 1);
      chk({nm, "_req_stall"}, 32'(stall), 1);
      chk({nm, "_addr"}, data_addr, addr);
      chk({nm, "_wr"}, 32'(data_wr), 32'(!ld));
      chk({nm, "_size"}, 32'(data_size), 32'(exp_sz));
      chk({nm, "_wstrb"}, 32'(data_wstrb), 32'(exp_strb));
      chk({nm, "_wdata"}, data_wdata, exp_wd);
      step();
    end
    data_addr_ok = 0;
    for (int i = 0; i <= dok_dly; i++) begin
      flush = flush_w && (i == 0);
      data_data_ok = (i == dok_dly);
      data_rdata = (i == dok_dly) ? rdata : 32'h0;
      #1;
      chk({nm, "_wait_stall"}, 32'(stall), 1);
      chk({nm, "_wait_req"}, 32'(data_req), 0);
      step();
    end
    flush = 0; data_data_ok = 0; data_rdata = 0;
    e = sb_q.pop_front();
    #1;
    chk({nm, "_done_stall"}, 32'(stall), 0);
    chk({nm, "_ld_valid"}, 32'(ld_valid), 32'(e.valid));
    chk({nm, "_ld_rdata"}, ld_rdata, e.rdata);
    chk({nm, "_ld_memtoreg"}, 32'(ld_memtoreg), 32'(e.mask));
    chk({nm, "_ld_offset"}, 32'(ld_offset), 32'(e.off));
    chk({nm, "_ld_lu"}, 32'(ld_lu), 32'(e.lu));
    pipe_advance = e.hold;
    step();
    pipe_advance = 0;
    #1;
    chk({nm, "_idle_valid"}, 32'(ld_valid), 0);
    chk({nm, "_idle_stall"}, 32'(stall), 0);
    chk({nm, "_idle_req"}, 32'(data_req), 0);
  endtask

  // Op that must be rejected (address error or flush): no request, no stall
  task automatic bad_op(input string nm, input logic ld, input logic [1:0] sz,
                        input logic [31:0] addr, input logic fl,
                        input logic exp_adel, input logic exp_ades);
    mem_valid = 1; mem_load = ld; mem_store = !ld; mem_size = sz; mem_addr = addr;
    flush = fl;
    #1;
    chk({nm, "_adel"}, 32'(adel), 32'(exp_adel));
    chk({nm, "_ades"}, 32'(ades), 32'(exp_ades));
    chk({nm, "_stall"}, 32'(stall), 0);
    step();
    clear_mem();
    flush = 0;
    #1;
    chk({nm, "_no_req"}, 32'(data_req), 0);
    chk({nm, "_no_stall"}, 32'(stall), 0);
  endtask

  initial begin
    resetn = 0; clear_mem();
    pipe_advance = 0; flush = 0; data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
    step(); step();
    resetn = 1;
    #1;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_req", 32'(data_req), 0);
    chk("rst_ld_valid", 32'(ld_valid), 0);
    chk("rst_memtoreg", 32'(ld_memtoreg), 0);
    chk("rst_rdata", ld_rdata, 0);
    chk("rst_addr", data_addr, 0);
    step();

    sb_q.push_back('{1'b1, 4'b0001, 2'd3, 1'b0, 32'h80FF1234, 1'b1});
    do_op("lb", 1, 2'd0, 32'h1003, 32'h0, 0, 1, 1, 32'h80FF1234, 0, 4'b0000, 32'h0, 2'd0);

    sb_q.push_back('{1'b0, 4'b0000, 2'd2, 1'b0, 32'hDEADBEEF, 1'b1});
    do_op("sh", 0, 2'd1, 32'h2002, 32'h1234ABCD, 0, 0, 0, 32'hDEADBEEF, 0, 4'b1100, 32'hABCDABCD, 2'd1);

    sb_q.push_back('{1'b0, 4'b0000, 2'd1, 1'b0, 32'h00000000, 1'b1});
    do_op("sb", 0, 2'd0, 32'h0011, 32'h0000005A, 0, 0, 0, 32'h0, 0, 4'b0010, 32'h5A5A5A5A, 2'd0);

    bad_op("lw_mis", 1, 2'd2, 32'h0006, 0, 1, 0);
    bad_op("sw_mis", 0, 2'd2, 32'h0001, 0, 0, 1);
    bad_op("lh_mis", 1, 2'd1, 32'h0003, 0, 1, 0);
    bad_op("sh_mis", 0, 2'd1, 32'h0001, 0, 0, 1);
    bad_op("sz3_mis", 1, 2'd3, 32'h0002, 0, 1, 0);
    bad_op("lw_flush", 1, 2'd2, 32'h0008, 1, 0, 0);

    // Cancelled load: only ld_rdata is refreshed, lane controls keep the SB values
    sb_q.push_back('{1'b0, 4'b0000, 2'd1, 1'b0, 32'hCAFEF00D, 1'b0});
    do_op("lhu_flush", 1, 2'd1, 32'h0010, 32'h0, 1, 0, 1, 32'hCAFEF00D, 1, 4'b0000, 32'h0, 2'd1);

    sb_q.push_back('{1'b1, 4'b0011, 2'd2, 1'b1, 32'h8001FFFF, 1'b1});
    do_op("lhu", 1, 2'd1, 32'h0012, 32'h0, 1, 0, 0, 32'h8001FFFF, 0, 4'b0000, 32'h0, 2'd1);

    sb_q.push_back('{1'b1, 4'b1111, 2'd0, 1'b0, 32'h12345678, 1'b1});
    do_op("lw_slow", 1, 2'd3, 32'h0040, 32'h0, 0, 5, 0, 32'h12345678, 0, 4'b0000, 32'h0, 2'd2);

    // Reset while in WAIT, then a stray data_ok in IDLE
    mem_valid = 1; mem_load = 1; mem_size = 2'd2; mem_addr = 32'h0100;
    step();
    clear_mem();
    data_addr_ok = 1;
    step();
    data_addr_ok = 0;
    #1;
    chk("rstw_wait_stall", 32'(stall), 1);
    resetn = 0;
    step();
    resetn = 1;
    #1;
    chk("rstw_stall", 32'(stall), 0);
    chk("rstw_req", 32'(data_req), 0);
    chk("rstw_ld_valid", 32'(ld_valid), 0);
    chk("rstw_memtoreg", 32'(ld_memtoreg), 0);
    chk("rstw_offset", 32'(ld_offset), 0);
    chk("rstw_lu", 32'(ld_lu), 0);
    chk("rstw_rdata", ld_rdata, 0);
    chk("rstw_addr", data_addr, 0);
    data_data_ok = 1; data_rdata = 32'h55AA55AA;
    step();
    data_data_ok = 0; data_rdata = 0;
    #1;
    chk("late_ok_rdata", ld_rdata, 0);
    chk("late_ok_valid", 32'(ld_valid), 0);
    chk("late_ok_stall", 32'(stall), 0);
    chk("late_ok_req", 32'(data_req), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store sequencer in the MEM stage.
- Takes one memory op per instruction and drives the data-memory SRAM-like handshake.
- Stalls the pipeline until the op completes.
- Registers the lane-select controls (4-bit byte mask, byte offset, unsigned flag) and the raw read word for the load-extension mux in WB.
- Generates store byte strobes, lane-replicated write data, and address-error flags.

Parameters:
ADDR_W, 32, width of the data address bus (only [1:0] used for alignment/lanes).

Ports:
clk  in  1  clock.
resetn  in  1  synchronous active-low reset.
mem_valid  in  1  MEM-stage instruction valid.
mem_load  in  1  op is a load.
mem_store  in  1  op is a store.
mem_size  in  2  0=byte, 1=half, 2=word (3 treated as word).
mem_unsigned  in  1  zero-extend load (LBU/LHU).
mem_addr  in  ADDR_W  effective address.
mem_wdata  in  32  store data, low-aligned.
pipe_advance  in  1  downstream accepts MEM result this cycle.
flush  in  1  cancel current op (exception/eret).
data_req  out  1  memory request.
data_wr  out  1  1=write.
data_size  out  2  transfer size.
data_addr  out  ADDR_W  request address.
data_wstrb  out  4  store byte strobes.
data_wdata  out  32  lane-replicated store data.
data_addr_ok  in  1  request accepted.
data_data_ok  in  1  data returned / write done.
data_rdata  in  32  read word.
stall  out  1  freeze IF..MEM.
adel  out  1  load address error (combinational).
ades  out  1  store address error (combinational).
ld_valid  out  1  load result held for WB.
ld_memtoreg  out  4  lane mask: 0001 byte, 0011 half, 1111 word, 0000 store/none.
ld_offset  out  2  address[1:0] of the load.
ld_lu  out  1  unsigned load.
ld_rdata  out  32  captured raw read word.

Behaviour:
- States: IDLE, REQ, WAIT, HOLD.
- Reset (resetn=0 at clk edge): state=IDLE; cancel=0; all registered outputs 0. Reset mid-op abandons the transaction. Any data_data_ok arriving after reset in IDLE is ignored.
- Misalign: half with addr[0]=1, or word with addr[1:0]!=0.
  - adel = IDLE & mem_valid & mem_load & misalign.
  - ades = same condition with mem_store.
  - No request issued, no stall.
- new_op = IDLE & mem_valid & (mem_load|mem_store) & ~misalign & ~flush.
- IDLE: on new_op, latch addr, size, wr, wstrb, wdata, unsigned; go to REQ. Stall is asserted combinationally in the new_op cycle.
- REQ:
  - data_req=1; all request fields held stable.
  - data_addr_ok -> WAIT.
  - The request is never withdrawn.
- WAIT:
  - data_data_ok -> capture data_rdata into ld_rdata.
  - If cancel -> IDLE. Otherwise -> HOLD.
  - data_data_ok is never expected in the same cycle as data_addr_ok.
- HOLD:
  - stall=0; ld_valid=1 for loads only.
  - pipe_advance or flush -> IDLE. Otherwise stay.
  - A new op is recognised only from IDLE, one cycle later.
- stall = new_op | REQ | WAIT.
- flush in REQ or WAIT sets cancel. The transaction still completes, with no ld_valid, then returns to IDLE. cancel clears on entering IDLE.
- Strobes:
  - byte: 0001<<addr[1:0].
  - half: 0011<<{addr[1],0}.
  - word: 1111.
- wdata:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: as-is.
- data_wstrb=0 for loads.
- ld_memtoreg/ld_offset/ld_lu are loaded when leaving WAIT without cancel:
  - mask from size for loads, 0000 for stores.
  - ld_offset=addr[1:0].
- Minimum latency, addr_ok in the first REQ cycle and data_ok the next: op cycle, REQ, WAIT, HOLD. Stall lasts 3 cycles.

Test Plan:
1. LB addr 0x1003, size 0, addr_ok after 1 cycle, data_ok 2 cycles later with rdata 0x80FF1234 -> stall high until HOLD. ld_memtoreg=0001, ld_offset=3, ld_lu=0, ld_rdata=0x80FF1234, ld_valid=1 for one HOLD cycle with pipe_advance.
2. SH addr 0x2002, wdata 0xABCD -> data_wr=1, data_wstrb=1100, data_wdata=0xABCDABCD, data_size=1. ld_valid stays 0. Back in IDLE after pipe_advance.
3. LW addr 0x0006 -> adel=1 same cycle, data_req never asserted, stall=0. SW addr 0x0001 -> ades=1.
4. LHU 0x0010, flush asserted in WAIT -> data_req completes; on data_ok the FSM returns to IDLE, ld_valid=0, stall drops that cycle.
5. addr_ok withheld 5 cycles -> data_req and data_addr stay stable and stall stays high every cycle.
6. resetn=0 while in WAIT -> next cycle state IDLE, stall=0, data_req=0, all ld_* outputs 0. A late data_ok is ignored.
